// File: rtl/iob_timer_alarm_pkg.sv
// Shared timer alarm definitions: register word addresses, CTRL bit positions,
// channel register offsets and the time-width helper used by the alarm block.
package iob_timer_alarm_pkg;

  // Global register word addresses
  localparam int ADDR_CTRL    = 0;
  localparam int ADDR_PENDING = 1;
  localparam int ADDR_IRQ_EN  = 2;
  localparam int ADDR_ARMED   = 3;

  // Per-channel block: channel i starts at ADDR_CH_BASE + CH_STRIDE*i
  localparam int ADDR_CH_BASE = 8;
  localparam int CH_STRIDE    = 4;

  // Word offset inside a channel block
  typedef enum logic [1:0] {
    CH_CMP_LO = 2'd0,
    CH_CMP_HI = 2'd1,
    CH_PER_LO = 2'd2,
    CH_PER_HI = 2'd3
  } ch_reg_e;

  // CTRL register bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_RST_BIT    = 1;
  localparam int CTRL_SAMPLE_BIT = 2;

  // The timer count is two CPU words wide
  function automatic int time_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/iob_timer_alarm_cmp.sv
// Shared alarm comparator: decides whether the channel under the scan pointer
// fires and, when IOB_TIMER_ALARM_RELOAD_EN is defined, computes the reloaded
// compare value CMP+PER (wrapping modulo 2^TIME_W).
module iob_timer_alarm_cmp #(
  parameter int TIME_W = 64
) (
  input  logic [TIME_W-1:0] timer_value,
  input  logic [TIME_W-1:0] cmp,
`ifdef IOB_TIMER_ALARM_RELOAD_EN
  input  logic [TIME_W-1:0] per,
`endif
  input  logic              armed,
  output logic              fire,
  output logic              reload,
  output logic [TIME_W-1:0] cmp_next
);

  // Unsigned compare plus optional periodic reload of the compare value
  always_comb begin
    fire = armed && (timer_value >= cmp);
`ifdef IOB_TIMER_ALARM_RELOAD_EN
    reload   = fire && (per != '0);
    cmp_next = cmp + per;
`else
    reload   = 1'b0;
    cmp_next = cmp;
`endif
  end

endmodule

// File: rtl/iob_timer_alarm.sv
// Timer alarm block: CPU register file, timer control pulses and a scan
// pointer that walks the alarm channels one per cycle through one shared
// comparator. Define IOB_TIMER_ALARM_RELOAD_EN to add periodic reload (PER).
// CPU handshake: each cycle with valid=1 is one request (write if any wstrb
// bit is set, else read); ready pulses for one cycle on the following cycle
// with rdata registered alongside it.
module iob_timer_alarm
  import iob_timer_alarm_pkg::*;
#(
  parameter int N_ALARMS = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [2*DATA_W-1:0]   timer_value,
  output logic                  timer_enable,
  output logic                  timer_rst,
  output logic                  timer_sample,
  output logic                  irq
);

  localparam int TIME_W   = time_w(DATA_W);
  localparam int PTR_W    = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int CH_IDX_W = ADDR_W - 2;

  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                enable_q, enable_d;
  logic                trst_q, trst_d;
  logic                tsample_q, tsample_d;
  logic [N_ALARMS-1:0] pending_q, pending_d;
  logic [N_ALARMS-1:0] irq_en_q, irq_en_d;
  logic [N_ALARMS-1:0] armed_q, armed_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [TIME_W-1:0]   cmp_q [N_ALARMS];
  logic [TIME_W-1:0]   cmp_d [N_ALARMS];
`ifdef IOB_TIMER_ALARM_RELOAD_EN
  logic [TIME_W-1:0]   per_q [N_ALARMS];
  logic [TIME_W-1:0]   per_d [N_ALARMS];
  logic [TIME_W-1:0]   per_sel;
`endif

  logic                wr_en, rd_en;
  logic                hit_ctrl, hit_pending, hit_irq_en, hit_armed, hit_ch;
  logic [CH_IDX_W-1:0] ch_idx;
  ch_reg_e             ch_reg;
  logic [TIME_W-1:0]   cmp_sel;
  logic                armed_sel;
  logic                fire, reload;
  logic [TIME_W-1:0]   cmp_next;
  logic                eval_discard;

  assign wr_en       = valid & (|wstrb);
  assign rd_en       = valid & ~(|wstrb);
  assign hit_ctrl    = (address == ADDR_W'(ADDR_CTRL));
  assign hit_pending = (address == ADDR_W'(ADDR_PENDING));
  assign hit_irq_en  = (address == ADDR_W'(ADDR_IRQ_EN));
  assign hit_armed   = (address == ADDR_W'(ADDR_ARMED));
  assign ch_idx      = address[ADDR_W-1:2] - CH_IDX_W'(ADDR_CH_BASE / CH_STRIDE);
  assign hit_ch      = (address >= ADDR_W'(ADDR_CH_BASE)) && (ch_idx < CH_IDX_W'(N_ALARMS));
  assign ch_reg      = ch_reg_e'(address[1:0]);

  // Route the channel under the scan pointer to the shared comparator
  always_comb begin
    cmp_sel   = '0;
    armed_sel = 1'b0;
`ifdef IOB_TIMER_ALARM_RELOAD_EN
    per_sel   = '0;
`endif
    for (int i = 0; i < N_ALARMS; i++) begin
      if (ptr_q == PTR_W'(i)) begin
        cmp_sel   = cmp_q[i];
        armed_sel = armed_q[i];
`ifdef IOB_TIMER_ALARM_RELOAD_EN
        per_sel   = per_q[i];
`endif
      end
    end
  end

  iob_timer_alarm_cmp #(
    .TIME_W(TIME_W)
  ) u_cmp (
    .timer_value(timer_value),
    .cmp        (cmp_sel),
`ifdef IOB_TIMER_ALARM_RELOAD_EN
    .per        (per_sel),
`endif
    .armed      (armed_sel),
    .fire       (fire),
    .reload     (reload),
    .cmp_next   (cmp_next)
  );

  // Register file update, read mux, control pulses and scan-pointer advance
  always_comb begin
    ready_d      = valid;
    rdata_d      = '0;
    enable_d     = enable_q;
    trst_d       = 1'b0;
    tsample_d    = 1'b0;
    pending_d    = pending_q;
    irq_en_d     = irq_en_q;
    armed_d      = armed_q;
    cmp_d        = cmp_q;
`ifdef IOB_TIMER_ALARM_RELOAD_EN
    per_d        = per_q;
`endif
    eval_discard = 1'b0;
    ptr_d        = (ptr_q == PTR_W'(N_ALARMS - 1)) ? '0 : ptr_q + 1'b1;

    if (wr_en) begin
      if (hit_ctrl) begin
        enable_d  = wdata[CTRL_ENABLE_BIT];
        trst_d    = wdata[CTRL_RST_BIT];
        tsample_d = wdata[CTRL_SAMPLE_BIT];
      end
      if (hit_pending) pending_d = pending_q & ~wdata[N_ALARMS-1:0];
      if (hit_irq_en)  irq_en_d  = wdata[N_ALARMS-1:0];
      for (int i = 0; i < N_ALARMS; i++) begin
        if (hit_ch && (ch_idx == CH_IDX_W'(i))) begin
          case (ch_reg)
            CH_CMP_LO: cmp_d[i][DATA_W-1:0] = wdata;
            CH_CMP_HI: begin
              cmp_d[i][TIME_W-1:DATA_W] = wdata;
              armed_d[i]                = 1'b1;
            end
`ifdef IOB_TIMER_ALARM_RELOAD_EN
            CH_PER_LO: per_d[i][DATA_W-1:0]      = wdata;
            CH_PER_HI: per_d[i][TIME_W-1:DATA_W] = wdata;
`endif
            default: ;
          endcase
          // A CPU write to the channel being scanned supersedes this evaluation
`ifdef IOB_TIMER_ALARM_RELOAD_EN
          if (ptr_q == PTR_W'(i)) eval_discard = 1'b1;
`else
          if ((ptr_q == PTR_W'(i)) && ((ch_reg == CH_CMP_LO) || (ch_reg == CH_CMP_HI)))
            eval_discard = 1'b1;
`endif
        end
      end
    end

    // Fire is applied after the W1C so a coincident set wins
    if (fire && !eval_discard) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (ptr_q == PTR_W'(i)) begin
          pending_d[i] = 1'b1;
          if (reload) cmp_d[i]   = cmp_next;
          else        armed_d[i] = 1'b0;
        end
      end
    end

    if (rd_en) begin
      if (hit_ctrl)    rdata_d = DATA_W'(enable_q);
      if (hit_pending) rdata_d = DATA_W'(pending_q);
      if (hit_irq_en)  rdata_d = DATA_W'(irq_en_q);
      if (hit_armed)   rdata_d = DATA_W'(armed_q);
      for (int i = 0; i < N_ALARMS; i++) begin
        if (hit_ch && (ch_idx == CH_IDX_W'(i))) begin
          case (ch_reg)
            CH_CMP_LO: rdata_d = cmp_q[i][DATA_W-1:0];
            CH_CMP_HI: rdata_d = cmp_q[i][TIME_W-1:DATA_W];
`ifdef IOB_TIMER_ALARM_RELOAD_EN
            CH_PER_LO: rdata_d = per_q[i][DATA_W-1:0];
            CH_PER_HI: rdata_d = per_q[i][TIME_W-1:DATA_W];
`endif
            default:   rdata_d = '0;
          endcase
        end
      end
    end
  end

  // State registers; reset also aborts any in-flight CPU access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      enable_q  <= 1'b0;
      trst_q    <= 1'b0;
      tsample_q <= 1'b0;
      pending_q <= '0;
      irq_en_q  <= '0;
      armed_q   <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < N_ALARMS; i++) begin
        cmp_q[i] <= '0;
`ifdef IOB_TIMER_ALARM_RELOAD_EN
        per_q[i] <= '0;
`endif
      end
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      enable_q  <= enable_d;
      trst_q    <= trst_d;
      tsample_q <= tsample_d;
      pending_q <= pending_d;
      irq_en_q  <= irq_en_d;
      armed_q   <= armed_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        cmp_q[i] <= cmp_d[i];
`ifdef IOB_TIMER_ALARM_RELOAD_EN
        per_q[i] <= per_d[i];
`endif
      end
    end
  end

  assign ready        = ready_q;
  assign rdata        = rdata_q;
  assign timer_enable = enable_q;
  assign timer_rst    = trst_q;
  assign timer_sample = tsample_q;
  assign irq          = |(pending_q & irq_en_q);

endmodule

// File: doc/iob_timer_alarm.md
IOB_TIMER_ALARM -- requirements
Module: iob_timer_alarm

Interface
REQ-001 SHALL have parameter N_ALARMS, default 4, number of alarm channels, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 32, CPU data width; the time width is 2*DATA_W.
REQ-003 SHALL have parameter ADDR_W, default 6, CPU word-address width.
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 valid  input  1  CPU request strobe.
REQ-007 address  input  ADDR_W  CPU word address.
REQ-008 wdata  input  DATA_W  CPU write data.
REQ-009 wstrb  input  DATA_W/8  byte strobes; any strobe set means write, all clear means read.
REQ-010 rdata  output  DATA_W  read data, valid while ready=1.
REQ-011 ready  output  1  one-cycle request acknowledge.
REQ-012 timer_value  input  2*DATA_W  current count from the timer core.
REQ-013 timer_enable  output  1  count enable to the timer core.
REQ-014 timer_rst  output  1  one-cycle soft reset pulse to the timer core.
REQ-015 timer_sample  output  1  one-cycle sample pulse to the timer core.
REQ-016 irq  output  1  level interrupt: OR of (PENDING & IRQ_EN).

Function
REQ-017 Register map (word addresses): 0 CTRL, 1 PENDING, 2 IRQ_EN, 3 ARMED (read-only); for channel i, 8+4i CMP_LO, 9+4i CMP_HI, 10+4i PER_LO, 11+4i PER_HI.
REQ-018 CTRL write: bit0 sets timer_enable (held); bit1=1 pulses timer_rst for exactly one cycle; bit2=1 pulses timer_sample for exactly one cycle. CTRL read returns {0, timer_enable}.
REQ-019 ready SHALL assert exactly one cycle after valid and SHALL stay high for one cycle; rdata SHALL be registered with it. Unmapped reads return 0; unmapped writes are ignored.
REQ-020 Writing CMP_HI of channel i SHALL arm channel i; writing CMP_LO SHALL only update the low word.
REQ-021 Writing PENDING SHALL clear the bits written as 1 (write-1-to-clear).
REQ-022 A single shared 2*DATA_W unsigned comparator SHALL be used; a scan pointer SHALL advance 0..N_ALARMS-1 and wrap, one channel per cycle.
REQ-023 Fire condition: the channel at the pointer is armed and timer_value >= CMP (unsigned). On fire, PENDING[i] SHALL be set and, without reload, ARMED[i] SHALL be cleared.
REQ-024 Latency: PENDING SHALL be set no more than N_ALARMS+1 cycles after timer_value first meets the fire condition.
REQ-025 If a CPU write to channel i's CMP or PER registers coincides with the evaluation of channel i, the write SHALL win and that evaluation SHALL be discarded.
REQ-026 If a W1C of PENDING[i] coincides with a fire of channel i, the set SHALL win.
REQ-027 If timer_rst pulses, ARMED and PENDING SHALL be unchanged; comparisons resume against the new timer_value.
REQ-028 If CMP is written with a value <= timer_value, the channel SHALL fire on its next scan slot.

Reset
REQ-029 While rst=0: ready, rdata, timer_enable, timer_rst, timer_sample, irq, PENDING, IRQ_EN and ARMED SHALL be 0; the scan pointer SHALL be 0; CMP and PER SHALL be 0.
REQ-030 A reset asserted during a CPU access SHALL abort it; no ready SHALL be issued for the aborted access.

Configuration
REQ-031 Macro IOB_TIMER_ALARM_RELOAD_EN defined: on fire with PER != 0, CMP SHALL become CMP+PER (modulo 2^(2*DATA_W)) and the channel SHALL stay armed; with PER == 0 the channel disarms.
REQ-032 Macro not defined: PER registers SHALL not exist, PER addresses SHALL read 0, and every fire SHALL disarm.

Structure
REQ-033 Register address constants, CTRL bit positions and the time width SHALL live in the shared timer header, alongside the existing TIMER_* defines.
REQ-034 The comparator and optional reload adder SHALL form one sub-module, iob_timer_alarm_cmp; the register file and scan pointer SHALL stay in the top level.

Verification
REQ-035 Set CMP0 to 100 (LO=100, HI=0), timer counts from 0 -> PENDING[0]=1 when timer_value is in 100..104; ARMED[0]=0.
REQ-036 IRQ_EN=0x1, CMP0=50 and CMP1=50 -> both PENDING bits set, irq=1; W1C 0x1 -> irq=0 while PENDING=0x2.
REQ-037 Reload enabled, CMP2=200, PER2=100 -> fires near counts 200, 300 and 400; ARMED[2] stays 1.
REQ-038 CMP3=0xFFFFFFFF_FFFFFFF0, PER3=0x20 -> after the fire, CMP3 reads 0x0000000000000010 (wrap).
REQ-039 W1C of PENDING[1] in the same cycle as a channel-1 fire -> PENDING[1] reads 1.
REQ-040 CTRL write 0x6 -> timer_rst and timer_sample each high for exactly one cycle; timer_enable=0.
